serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
//
// PURPOSE
//   Bit-serial add/subtract controller. It time-shares one 1-bit full-adder
//   cell across a WIDTH-bit operation, feeding it one bit per cycle, LSB first.
//   It sits between a requester (valid/ready command port) and a consumer
//   (valid/ready result port). It trades latency for a single adder cell, for
//   area-constrained arithmetic paths.
//
// PARAMETERS
//   WIDTH   8   operand/result width in bits; legal range 2..64
//
// PORTS
//   clk          in   1       rising-edge clock
//   rst          in   1       reset; synchronous, active-high
//   start_valid  in   1       command valid
//   start_ready  out  1       command ready; 1 only in IDLE
//   a            in   WIDTH   operand A; sampled at the command handshake
//   b            in   WIDTH   operand B; sampled at the command handshake
//   cin          in   1       carry-in (add mode only)
//   op_sub       in   1       0 = A+B+cin; 1 = A-B (A + ~B + 1; cin ignored)
//   res_valid    out  1       result valid; held until res_ready
//   res_ready    in   1       result consumer ready
//   sum          out  WIDTH   result, registered
//   cout         out  1       carry out (in sub mode, 1 = no borrow)
//   ovf          out  1       signed overflow = carry into MSB ^ carry out of MSB
//   busy         out  1       1 in RUN or DONE
//
// BEHAVIOUR
//   - Reset: state=IDLE; start_ready=1; res_valid=0; busy=0; sum=0; cout=0;
//     ovf=0; bit counter=0; internal carry=0.
//   - FSM has three states: IDLE, RUN, DONE.
//   - IDLE -> RUN on start_valid & start_ready.
//     - Capture a into shift register A_sh.
//     - Capture b into B_sh, or ~b if op_sub=1.
//     - Carry register = op_sub ? 1 : cin.
//     - Counter = 0.
//   - RUN, each cycle:
//     - Adder cell sees A_sh[0], B_sh[0], carry.
//     - Its sum bit shifts into result register R at the MSB, shifting R right.
//     - A_sh and B_sh shift right; carry <= cell carry; counter++.
//     - When counter==WIDTH-2, save the cell carry-out as c_msb_in (carry into MSB).
//   - RUN -> DONE at the edge processing bit WIDTH-1.
//     - Load sum=R (including the final bit) and cout=final carry.
//     - Load ovf = c_msb_in ^ final carry.
//     - Set res_valid=1.
//   - Latency: the accept edge is edge 0. res_valid rises after edge WIDTH.
//     The result is visible WIDTH cycles after acceptance.
//   - DONE: sum, cout and ovf stay stable while res_valid=1 & !res_ready
//     (backpressure of any length).
//   - DONE -> IDLE on res_valid & res_ready. res_valid drops the next cycle.
//     The sum/cout/ovf registers keep their last value.
//   - start_ready=0 in RUN and DONE. There is no back-to-back overlap: at least
//     one IDLE cycle separates consecutive operations.
//   - Input changes on a, b, cin and op_sub after acceptance have no effect.
//   - rst asserted in any state: at the next edge, all reset values; any
//     in-flight operation is discarded and no res_valid is produced for it.
//   - Arithmetic is modulo 2^WIDTH. Counter width is $clog2(WIDTH).
//
// STRUCTURE
//   - Shared package serial_arith_pkg:
//     - typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} sa_state_t;
//     - localparam int SA_MAX_WIDTH = 64
//   - One sub-module: the team's existing 1-bit full-adder cell, instantiated
//     once as u_fa.
//     - Its rst is tied to 1'b0; its clk is tied to clk.
//     - The controller owns all state.
//   - Top level holds the FSM, counter, shift registers, carry/c_msb_in
//     registers and output registers.
//
// TESTING (WIDTH=8)
//   - Add, signed overflow: a=0x5A b=0x3C cin=0 op_sub=0
//       -> sum=0x96 cout=0 ovf=1; res_valid 8 cycles after accept.
//   - Add, unsigned wrap: a=0xFF b=0x01 cin=0
//       -> sum=0x00 cout=1 ovf=0.
//   - Add with carry-in: a=0x7F b=0x00 cin=1
//       -> sum=0x80 cout=0 ovf=1.
//   - Subtract with borrow: a=0x10 b=0x20 op_sub=1 cin=1 (cin ignored)
//       -> sum=0xF0 cout=0 ovf=0.
//   - Backpressure: hold res_ready=0 for 5 cycles
//       -> res_valid, sum, cout and ovf stable; start_ready=0 throughout;
//          with start_valid=1 held, no new accept until 1 cycle after the
//          result handshake.
//   - Reset mid-RUN: assert rst for 1 cycle at bit 3
//       -> next cycle IDLE, start_ready=1, res_valid=0, sum=0;
//          the following command completes correctly.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared types for the bit-serial arithmetic controller.
// FSM state encoding and the supported operand width ceiling.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } sa_state_t;

  localparam int SA_MAX_WIDTH = 64;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// 1-bit full-adder cell shared by the serial controller.
// Purely combinational; clk/rst exist only for cell compatibility.
module serial_add_ctrl_fa (
  input  logic clk,
  input  logic rst,
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic unused_ok;

  // Clock and reset are part of the cell footprint but hold no state here
  assign unused_ok = clk ^ rst;

  // Sum and carry of one bit position
  always_comb begin
    s  = x ^ y ^ ci;
    co = (x & y) | (x & ci) | (y & ci);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller around one full-adder cell.
// Operands stream LSB first; one bit per cycle, result held until taken.
module serial_add_ctrl
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int LIM_W = (WIDTH > SA_MAX_WIDTH) ? SA_MAX_WIDTH : WIDTH;
  localparam logic [CW-1:0] CNT_LAST = CW'(LIM_W - 1);
  localparam logic [CW-1:0] CNT_MSB = CW'(LIM_W - 2);

  sa_state_t state;
  sa_state_t nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             c_msb_in;
  logic             fa_s;
  logic             fa_co;
  logic             last;
  logic             accept;

  assign accept = start_valid & (state == S_IDLE);
  assign last   = (cnt == CNT_LAST);

  // Handshake outputs decode directly from the state register
  always_comb begin
    start_ready = (state == S_IDLE);
    res_valid   = (state == S_DONE);
    busy        = (state != S_IDLE);
  end

  serial_add_ctrl_fa u_fa (
    .clk (clk),
    .rst (1'b0),
    .x   (a_sh[0]),
    .y   (b_sh[0]),
    .ci  (carry),
    .s   (fa_s),
    .co  (fa_co)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    unique case (1'b1)
      (state == S_IDLE): if (start_valid) nxt = S_RUN;
      (state == S_RUN):  if (last) nxt = S_DONE;
      (state == S_DONE): if (res_ready) nxt = S_IDLE;
      default:           nxt = S_IDLE;
    endcase
  end

  // Operand capture, serial shifting and result load
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      c_msb_in <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (accept) begin
        a_sh  <= a;
        b_sh  <= op_sub ? ~b : b;
        carry <= op_sub ? 1'b1 : cin;
        cnt   <= '0;
      end else if (state == S_RUN) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        r_sh  <= {fa_s, r_sh[WIDTH-1:1]};
        carry <= fa_co;
        cnt   <= cnt + CW'(1);
        if (cnt == CNT_MSB) begin
          c_msb_in <= fa_co;
        end
        if (last) begin
          sum  <= {fa_s, r_sh[WIDTH-1:1]};
          cout <= fa_co;
          ovf  <= c_msb_in ^ fa_co;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8.
// Hand-computed vectors, backpressure and mid-run reset.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       op_sub = 1'b0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;
  logic       busy;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .op_sub      (op_sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf),
    .busy        (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one command, then scramble the inputs after acceptance
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib,
                       input logic ic, input logic is);
    int n;
    n = 0;
    while (!start_ready && n < 50) begin
      step();
      n++;
    end
    n_checks++;
    if (!start_ready) begin
      n_fail++;
      $display("FAIL issue_timeout: start_ready=%0b required 1", start_ready);
    end
    a = ia;
    b = ib;
    cin = ic;
    op_sub = is;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    a = ~ia;
    b = ~ib;
    cin = ~ic;
    op_sub = ~is;
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (!res_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if ({start_ready, res_valid, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_hs: rdy/vld/busy=%b required 100",
               {start_ready, res_valid, busy});
    end
    n_checks++;
    if ({sum, cout, ovf} !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_out: sum=%h cout=%b ovf=%b required 00 0 0",
               sum, cout, ovf);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_arith();
    logic [7:0] va [5];
    logic [7:0] vb [5];
    logic       vc [5];
    logic       vs [5];
    logic [7:0] es [5];
    logic       ec [5];
    logic       eo [5];
    int n;
    va = '{8'h5A, 8'hFF, 8'h7F, 8'h10, 8'h80};
    vb = '{8'h3C, 8'h01, 8'h00, 8'h20, 8'h01};
    vc = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    es = '{8'h96, 8'h00, 8'h80, 8'hF0, 8'h7F};
    ec = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    eo = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      issue(va[i], vb[i], vc[i], vs[i]);
      n_checks++;
      if ({busy, start_ready} !== 2'b10) begin
        n_fail++;
        $display("FAIL arith%0d_busy: busy/rdy=%b required 10",
                 i, {busy, start_ready});
      end
      wait_res(n);
      n_checks++;
      if (n !== 8) begin
        n_fail++;
        $display("FAIL arith%0d_latency: %0d cycles required 8", i, n);
      end
      n_checks++;
      if ({sum, cout, ovf} !== {es[i], ec[i], eo[i]}) begin
        n_fail++;
        $display("FAIL arith%0d_result: sum=%h c=%b v=%b required %h %b %b",
                 i, sum, cout, ovf, es[i], ec[i], eo[i]);
      end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      n_checks++;
      if ({res_valid, start_ready, sum} !== {2'b01, es[i]}) begin
        n_fail++;
        $display("FAIL arith%0d_release: vld=%b rdy=%b sum=%h required 0 1 %h",
                 i, res_valid, start_ready, sum, es[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    a = 8'h12;
    b = 8'h34;
    cin = 1'b0;
    op_sub = 1'b0;
    start_valid = 1'b1;
    step();
    a = 8'h01;
    b = 8'h02;
    wait_res(n);
    n_checks++;
    if (n !== 8) begin
      n_fail++;
      $display("FAIL bp_latency: %0d cycles required 8", n);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if ({res_valid, start_ready, sum, cout, ovf} !== {2'b10, 8'h46, 2'b00}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: vld=%b rdy=%b sum=%h c=%b v=%b required 1 0 46 0 0",
                 i, res_valid, start_ready, sum, cout, ovf);
      end
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    n_checks++;
    if ({busy, start_ready, res_valid} !== 3'b010) begin
      n_fail++;
      $display("FAIL bp_idle_gap: busy/rdy/vld=%b required 010",
               {busy, start_ready, res_valid});
    end
    step();
    start_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_reaccept: busy=%b required 1", busy);
    end
    wait_res(n);
    n_checks++;
    if ({n[7:0], sum, cout, ovf} !== {8'd8, 8'h03, 2'b00}) begin
      n_fail++;
      $display("FAIL bp_second: lat=%0d sum=%h c=%b v=%b required 8 03 0 0",
               n, sum, cout, ovf);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int n;
    issue(8'h5A, 8'h3C, 1'b0, 1'b0);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({start_ready, res_valid, busy, sum, cout, ovf} !== {3'b100, 10'h000}) begin
      n_fail++;
      $display("FAIL rst_mid: rdy=%b vld=%b busy=%b sum=%h c=%b v=%b required 1 0 0 00 0 0",
               start_ready, res_valid, busy, sum, cout, ovf);
    end
    for (int i = 0; i < 10; i++) begin
      step();
    end
    n_checks++;
    if ({res_valid, start_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_no_result: vld=%b rdy=%b required 0 1",
               res_valid, start_ready);
    end
    issue(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_res(n);
    n_checks++;
    if ({n[7:0], sum, cout, ovf} !== {8'd8, 8'h00, 2'b10}) begin
      n_fail++;
      $display("FAIL rst_next_op: lat=%0d sum=%h c=%b v=%b required 8 00 1 0",
               n, sum, cout, ovf);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
